// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: state encoding, cause codes and default trap vector
package trap_sequencer_pkg;
  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SAVE    = 3'd1,
    S_HANDLER = 3'd2,
    S_RETURN  = 3'd3,
    S_HALT    = 3'd4
  } state_t;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;
  localparam logic [1:0] CAUSE_IRQ  = 2'b11;
  localparam logic [31:0] TRAP_VECTOR_DEF = 32'd96;
endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: commit-stage inputs and PC-control outputs of the trap sequencer
interface trap_sequencer_if #(parameter int CNT_W = 8);
  logic             instr_valid;
  logic [31:0]      pc_cur;
  logic             invalid;
  logic [31:0]      target_addr;
  logic             pc_src;
  logic             ext_irq;
  logic             mret;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             stall;
  logic [31:0]      epc;
  logic [1:0]       cause;
  logic             in_handler;
  logic             halted;
  logic [CNT_W-1:0] trap_count;
  modport master (
    output instr_valid, pc_cur, invalid, target_addr, pc_src, ext_irq, mret,
    input  redirect, redirect_pc, stall, epc, cause, in_handler, halted, trap_count
  );
  modport slave (
    input  instr_valid, pc_cur, invalid, target_addr, pc_src, ext_irq, mret,
    output redirect, redirect_pc, stall, epc, cause, in_handler, halted, trap_count
  );
endinterface

// File: rtl/trap_sequencer_prio_enc.sv
// trap_prio_enc: picks the highest-priority trap source of a committing instruction
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic       i_valid,
  input  logic       i_ill,
  input  logic       i_mis,
  input  logic       i_irq,
  output logic       o_trap,
  output logic [1:0] o_code
);
  always_comb begin
    o_trap = i_valid & (i_ill | i_mis | i_irq);
    o_code = i_ill ? CAUSE_ILL : i_mis ? CAUSE_MIS : i_irq ? CAUSE_IRQ : CAUSE_NONE;
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: trap entry/return FSM with saved PC, cause and saturating trap counter
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
  parameter int          CNT_W       = 8
) (
  input logic              clk,
  input logic              rst_n,
  trap_sequencer_if.slave  bus
);
  state_t           r_state, w_next;
  logic [31:0]      r_epc;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_count;
  logic             w_mis, w_fault, w_trap;
  logic [1:0]       w_code;

  // mret outside a handler is treated as an illegal instruction
  trap_prio_enc u_enc (
    .i_valid (bus.instr_valid),
    .i_ill   (bus.invalid | bus.mret),
    .i_mis   (w_mis),
    .i_irq   (bus.ext_irq),
    .o_trap  (w_trap),
    .o_code  (w_code)
  );

  always_comb begin
    w_mis   = bus.instr_valid & bus.pc_src & (bus.target_addr[1:0] != 2'b00);
    w_fault = bus.instr_valid & (bus.invalid | w_mis);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_RUN;
      r_epc   <= '0;
      r_cause <= CAUSE_NONE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN && w_trap) begin
        r_epc   <= bus.pc_cur;
        r_cause <= w_code;
        r_count <= (&r_count) ? r_count : r_count + 1'b1;
      end else if (r_state == S_RETURN)
        r_cause <= CAUSE_NONE;
    end

  // a fault inside the handler wins over a simultaneous mret
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:     w_next = w_trap ? S_SAVE : S_RUN;
      S_SAVE:    w_next = S_HANDLER;
      S_HANDLER: w_next = w_fault ? S_HALT : (bus.instr_valid & bus.mret) ? S_RETURN : S_HANDLER;
      S_RETURN:  w_next = S_RUN;
      default:   w_next = S_HALT;
    endcase
  end

  always_comb begin
    bus.redirect    = (r_state == S_SAVE) || (r_state == S_RETURN);
    bus.stall       = (r_state == S_SAVE) || (r_state == S_RETURN) || (r_state == S_HALT);
    bus.redirect_pc = (r_state == S_SAVE) ? TRAP_VECTOR :
                      (r_state == S_RETURN) ? ((r_cause == CAUSE_IRQ) ? r_epc : r_epc + 32'd4) : '0;
    bus.in_handler  = r_state == S_HANDLER;
    bus.halted      = r_state == S_HALT;
    bus.epc         = r_epc;
    bus.cause       = r_cause;
    bus.trap_count  = r_count;
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench; every redirect strobe is matched against a queued expectation
module tb_trap_sequencer;
  typedef struct {
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];
  logic [7:0]  m_cnt;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;

  trap_sequencer_if #(.CNT_W(8)) bus ();
  trap_sequencer #(.TRAP_VECTOR(32'd96), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk)
    if (rst_n && bus.redirect) begin
      if (q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("redirect_pc", bus.redirect_pc, e.rpc);
        chk("redirect_stall", {31'd0, bus.stall}, 32'd1);
        chk("redirect_epc", bus.epc, e.epc);
        chk("redirect_cause", {30'd0, bus.cause}, {30'd0, e.cause});
        chk("redirect_count", {24'd0, bus.trap_count}, {24'd0, e.cnt});
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.instr_valid = 0; bus.pc_cur = '0; bus.invalid = 0; bus.target_addr = '0;
    bus.pc_src = 0; bus.ext_irq = 0; bus.mret = 0;
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic inv, input logic mr, input logic ps,
                         input logic [31:0] tgt, input logic irq, input logic [1:0] c);
    exp_t e;
    bus.instr_valid = 1; bus.pc_cur = pc; bus.invalid = inv; bus.mret = mr;
    bus.pc_src = ps; bus.target_addr = tgt; bus.ext_irq = irq;
    m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
    m_epc = pc;
    m_cause = c;
    e = '{32'd96, pc, c, m_cnt};
    q.push_back(e);
    step();
    clear();
    step();
  endtask

  task automatic do_ret();
    exp_t e;
    bus.instr_valid = 1; bus.mret = 1;
    e = '{(m_cause == 2'b11) ? m_epc : m_epc + 32'd4, m_epc, m_cause, m_cnt};
    q.push_back(e);
    step();
    clear();
    step();
    m_cause = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear();
    m_cnt = 0; m_epc = 0; m_cause = 0;
    #1;
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_in_handler", {31'd0, bus.in_handler}, 32'd0);
    chk("rst_epc", bus.epc, 32'd0);
    chk("rst_cause", {30'd0, bus.cause}, 32'd0);
    chk("rst_count", {24'd0, bus.trap_count}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    clear();
    #12;
    do_reset();
    do_trap(32'h40, 1, 0, 0, 0, 0, 2'b01);
    chk("ill_in_handler", {31'd0, bus.in_handler}, 32'd1);
    chk("ill_epc", bus.epc, 32'h40);
    do_ret();
    chk("ret_cause_cleared", {30'd0, bus.cause}, 32'd0);
    chk("ret_run_stall", {31'd0, bus.stall}, 32'd0);
    do_trap(32'h20, 0, 0, 1, 32'h102, 0, 2'b10);
    chk("mis_cause", {30'd0, bus.cause}, 32'd2);
    do_ret();
    bus.instr_valid = 1; bus.pc_src = 1; bus.target_addr = 32'h100; bus.pc_cur = 32'h24;
    step();
    clear();
    chk("aligned_no_trap", {31'd0, bus.stall}, 32'd0);
    do_trap(32'h80, 0, 0, 0, 0, 1, 2'b11);
    bus.ext_irq = 1; bus.instr_valid = 1; bus.pc_cur = 32'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("irq_masked", {31'd0, bus.in_handler}, 32'd1);
    end
    do_ret();
    chk("irq_back_run", {31'd0, bus.in_handler}, 32'd0);
    bus.invalid = 1; bus.ext_irq = 1; bus.mret = 1;
    step();
    step();
    chk("no_valid_no_trap", {31'd0, bus.stall}, 32'd0);
    clear();
    do_trap(32'h200, 0, 1, 0, 0, 0, 2'b01);
    do_ret();
    do_trap(32'h300, 1, 0, 0, 0, 1, 2'b01);
    chk("ill_beats_irq", {30'd0, bus.cause}, 32'd1);
    bus.invalid = 1;
    step();
    chk("handler_no_valid", {31'd0, bus.halted}, 32'd0);
    bus.instr_valid = 1;
    step();
    clear();
    chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_stall", {31'd0, bus.stall}, 32'd1);
    chk("halt_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("halt_epc", bus.epc, 32'h300);
    bus.instr_valid = 1; bus.mret = 1;
    for (int i = 0; i < 3; i++) step();
    clear();
    chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
    do_reset();
    do_trap(32'h10, 1, 0, 0, 0, 0, 2'b01);
    bus.instr_valid = 1; bus.mret = 1; bus.invalid = 1;
    step();
    clear();
    chk("fault_beats_mret", {31'd0, bus.halted}, 32'd1);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_trap(32'h400 + 32'(i * 4), 1, 0, 0, 0, 0, 2'b01);
      do_ret();
    end
    chk("count_saturated", {24'd0, bus.trap_count}, 32'd255);
    do_reset();
    bus.instr_valid = 1; bus.invalid = 1; bus.pc_cur = 32'h500;
    step();
    chk("save_before_reset", {31'd0, bus.redirect}, 32'd1);
    rst_n = 0;
    clear();
    #1;
    chk("save_reset_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("save_reset_epc", bus.epc, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    step();
    step();
    chk("post_reset_stall", {31'd0, bus.stall}, 32'd0);
    step();
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
